// File: rtl/regfile_pkg.sv
// Shared types, default sizes and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 4;

    // True when an address names a real entry; DEPTH need not be a power of two.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: sweeps every entry once, one per cycle, after clr_req.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    clr_state_e        state;
    clr_state_e        state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    // State and sweep counter registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: start on clr_req, zero one entry per cycle, stop after the last.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port register file: one write port, NUM_RD registered read ports,
// sequenced soft clear. Define REGFILE_BYPASS_EN to forward a same-cycle
// accepted write to reads of the same address; otherwise reads see the old value.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_err
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    regfile_clr_seq #(
        .DEPTH(DEPTH)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // A user write lands only in IDLE, in range, and not in the cycle a clear starts.
    assign wr_ok = wr_en && addr_in_range(32'(wr_addr), unsigned'(DEPTH)) && !busy && !clr_req;

    // Storage: the clear sweep has priority over user writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Rejected writes report one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_next;
        logic [DATA_W-1:0] data_q;
        logic              valid_q;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        // Select the read value: out-of-range reads give zero, optional forwarding.
        always_comb begin
            data_next = '0;
            if (addr_in_range(32'(addr), unsigned'(DEPTH))) begin
                data_next = mem[addr];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (wr_addr == addr)) begin
                    data_next = wr_data;
                end
`endif
            end
        end

        // Read port register: data holds while rd_en is low, valid follows rd_en.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_en[p];
                if (rd_en[p]) begin
                    data_q <= data_next;
                end
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data_q;
        assign rd_valid[p]                 = valid_q;
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed testbench for multiport_regfile (DEPTH=32 main instance, DEPTH=20 range instance).
module tb_multiport_regfile;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DATA_W=8, DEPTH=32, NUM_RD=4 (ADDR_W=5)
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  rd_en;
    logic [19:0] rd_addr;
    logic [31:0] rd_data;
    logic [3:0]  rd_valid;
    logic        clr_req;
    logic        busy;
    logic        wr_err;

    // Instance B: DATA_W=8, DEPTH=20, NUM_RD=4 (ADDR_W=5)
    logic        b_wr_en;
    logic [4:0]  b_wr_addr;
    logic [7:0]  b_wr_data;
    logic [3:0]  b_rd_en;
    logic [19:0] b_rd_addr;
    logic [31:0] b_rd_data;
    logic [3:0]  b_rd_valid;
    logic        b_clr_req;
    logic        b_busy;
    logic        b_wr_err;

    int n_checks = 0;
    int n_fail   = 0;

    multiport_regfile #(.DATA_W(8), .DEPTH(32), .NUM_RD(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
    );

    multiport_regfile #(.DATA_W(8), .DEPTH(20), .NUM_RD(4)) dut20 (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .clr_req(b_clr_req), .busy(b_busy), .wr_err(b_wr_err)
    );

    function automatic logic [7:0] a_port(input int p);
        return rd_data[p*8 +: 8];
    endfunction

    function automatic logic [7:0] b_port(input int p);
        return b_rd_data[p*8 +: 8];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic a_read_all(input logic [4:0] a);
        rd_en = 4'hF;
        for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = a;
        tick();
        rd_en = 4'h0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, 32'h0); end
        n_checks++; if (rd_valid !== 4'h0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected %b", rd_valid, 4'h0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
        n_checks++; if (b_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_b_rd_data: got %h expected 0", b_rd_data); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        a_read_all(5'd9);
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_entry_zero: got %h expected 0", rd_data); end
    endtask

    task automatic test_basic;
        a_write(5'd3, 8'hA5);
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err: got %b expected 0", wr_err); end
        a_read_all(5'd3);
        for (int p = 0; p < 4; p++) begin
            n_checks++; if (a_port(p) !== 8'hA5) begin n_fail++; $display("FAIL basic_rd_data port %0d: got %h expected a5", p, a_port(p)); end
        end
        n_checks++; if (rd_valid !== 4'hF) begin n_fail++; $display("FAIL basic_rd_valid: got %b expected 1111", rd_valid); end
        tick();
        n_checks++; if (rd_valid !== 4'h0) begin n_fail++; $display("FAIL basic_valid_drop: got %b expected 0000", rd_valid); end
        n_checks++; if (a_port(2) !== 8'hA5) begin n_fail++; $display("FAIL basic_hold: got %h expected a5", a_port(2)); end
    endtask

    task automatic test_hazard;
        logic [7:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 8'h22;
`else
        exp_same = 8'h11;
`endif
        a_write(5'd7, 8'h11);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 8'h22;
        rd_en   = 4'b0001;
        rd_addr[4:0] = 5'd7;
        tick();
        wr_en = 1'b0;
        rd_en = 4'h0;
        n_checks++; if (a_port(0) !== exp_same) begin n_fail++; $display("FAIL hazard_same_cycle: got %h expected %h", a_port(0), exp_same); end
        a_read_all(5'd7);
        n_checks++; if (a_port(0) !== 8'h22) begin n_fail++; $display("FAIL hazard_next_read: got %h expected 22", a_port(0)); end
    endtask

    task automatic test_hold;
        a_write(5'd1, 8'h01);
        a_write(5'd2, 8'h02);
        a_write(5'd4, 8'h04);
        rd_en = 4'b0011;
        rd_addr[4:0] = 5'd1;
        rd_addr[9:5] = 5'd2;
        tick();
        n_checks++; if (a_port(0) !== 8'h01) begin n_fail++; $display("FAIL hold_p0_first: got %h expected 01", a_port(0)); end
        n_checks++; if (a_port(1) !== 8'h02) begin n_fail++; $display("FAIL hold_p1_first: got %h expected 02", a_port(1)); end
        n_checks++; if (rd_valid !== 4'b0011) begin n_fail++; $display("FAIL hold_valid_first: got %b expected 0011", rd_valid); end
        rd_en = 4'b0010;
        rd_addr[4:0] = 5'd2;
        rd_addr[9:5] = 5'd4;
        tick();
        rd_en = 4'h0;
        n_checks++; if (a_port(0) !== 8'h01) begin n_fail++; $display("FAIL hold_p0_held: got %h expected 01", a_port(0)); end
        n_checks++; if (rd_valid[0] !== 1'b0) begin n_fail++; $display("FAIL hold_p0_valid: got %b expected 0", rd_valid[0]); end
        n_checks++; if (a_port(1) !== 8'h04) begin n_fail++; $display("FAIL hold_p1_second: got %h expected 04", a_port(1)); end
        n_checks++; if (rd_valid[1] !== 1'b1) begin n_fail++; $display("FAIL hold_p1_valid: got %b expected 1", rd_valid[1]); end
    endtask

    task automatic test_soft_clear;
        int n_busy;
        for (int i = 0; i < 32; i++) a_write(5'(i), 8'hFF);
        // clr_req accepted together with a write: the write is rejected
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd6;
        wr_data = 8'h12;
        tick();
        clr_req = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_rise: got %b expected 1", busy); end
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL clear_wr_err_same_cycle: got %b expected 1", wr_err); end
        n_busy = 1;
        // write during busy, plus reads of the entry being zeroed and an unswept one
        wr_addr = 5'd5;
        wr_data = 8'h33;
        rd_en   = 4'b0011;
        rd_addr[4:0] = 5'd0;
        rd_addr[9:5] = 5'd31;
        tick();
        wr_en = 1'b0;
        if (busy) n_busy++;
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL clear_wr_err_busy: got %b expected 1", wr_err); end
        n_checks++; if (a_port(0) !== 8'hFF) begin n_fail++; $display("FAIL clear_read_in_sweep: got %h expected ff", a_port(0)); end
        n_checks++; if (a_port(1) !== 8'hFF) begin n_fail++; $display("FAIL clear_read_unswept: got %h expected ff", a_port(1)); end
        tick();
        rd_en = 4'h0;
        if (busy) n_busy++;
        n_checks++; if (a_port(0) !== 8'h00) begin n_fail++; $display("FAIL clear_read_swept: got %h expected 00", a_port(0)); end
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL clear_wr_err_pulse: got %b expected 0", wr_err); end
        for (int i = 0; i < 64 && busy; i++) begin
            tick();
            if (busy) n_busy++;
        end
        n_checks++; if (n_busy != 32) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 32", n_busy); end
        for (int a = 0; a < 32; a += 4) begin
            rd_en = 4'hF;
            for (int p = 0; p < 4; p++) rd_addr[p*5 +: 5] = 5'(a + p);
            tick();
            rd_en = 4'h0;
            n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL clear_all_zero addr %0d: got %h expected 0", a, rd_data); end
        end
        a_write(5'd31, 8'h9C);
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL clear_post_write_err: got %b expected 0", wr_err); end
        a_read_all(5'd31);
        n_checks++; if (a_port(3) !== 8'h9C) begin n_fail++; $display("FAIL clear_post_write: got %h expected 9c", a_port(3)); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] exp;
        b_wr_en = 1'b1; b_wr_addr = 5'd19; b_wr_data = 8'h77;
        tick();
        b_wr_addr = 5'd25; b_wr_data = 8'h5A;
        tick();
        b_wr_en = 1'b0;
        n_checks++; if (b_wr_err !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", b_wr_err); end
        tick();
        n_checks++; if (b_wr_err !== 1'b0) begin n_fail++; $display("FAIL oor_wr_err_pulse: got %b expected 0", b_wr_err); end
        for (int a = 0; a < 20; a += 4) begin
            b_rd_en = 4'hF;
            for (int p = 0; p < 4; p++) b_rd_addr[p*5 +: 5] = 5'(a + p);
            tick();
            b_rd_en = 4'h0;
            for (int p = 0; p < 4; p++) begin
                exp = (a + p == 19) ? 8'h77 : 8'h00;
                n_checks++; if (b_port(p) !== exp) begin n_fail++; $display("FAIL oor_entry %0d: got %h expected %h", a + p, b_port(p), exp); end
            end
        end
        b_rd_en = 4'b0001;
        b_rd_addr[4:0] = 5'd19;
        tick();
        n_checks++; if (b_port(0) !== 8'h77) begin n_fail++; $display("FAIL oor_prior_read: got %h expected 77", b_port(0)); end
        b_rd_addr[4:0] = 5'd25;
        tick();
        b_rd_en = 4'h0;
        n_checks++; if (b_port(0) !== 8'h00) begin n_fail++; $display("FAIL oor_read_data: got %h expected 00", b_port(0)); end
        n_checks++; if (b_rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL oor_read_valid: got %b expected 1", b_rd_valid[0]); end
    endtask

    task automatic test_reset_mid_clear;
        a_write(5'd20, 8'h44);
        a_write(5'd2, 8'h55);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy_async: got %b expected 0", busy); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midclr_rd_data: got %h expected 0", rd_data); end
        #2;
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_idle: got %b expected 0", busy); end
        rd_en = 4'b0011;
        rd_addr[4:0] = 5'd20;
        rd_addr[9:5] = 5'd2;
        tick();
        rd_en = 4'h0;
        n_checks++; if (a_port(0) !== 8'h00) begin n_fail++; $display("FAIL midclr_unswept_zero: got %h expected 00", a_port(0)); end
        n_checks++; if (a_port(1) !== 8'h00) begin n_fail++; $display("FAIL midclr_swept_zero: got %h expected 00", a_port(1)); end
        a_write(5'd12, 8'h66);
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL midclr_write_err: got %b expected 0", wr_err); end
        a_read_all(5'd12);
        n_checks++; if (a_port(2) !== 8'h66) begin n_fail++; $display("FAIL midclr_write_back: got %h expected 66", a_port(2)); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0; clr_req = 1'b0;
        b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0; b_clr_req = 1'b0;
        test_reset();
        test_basic();
        test_hazard();
        test_hold();
        test_soft_clear();
        test_out_of_range();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised multi-port register file for the CNN accelerator datapath, holding weights, partial sums and addresses for the processing elements. It provides one write port and NUM_RD registered read ports with per-port valid, an asynchronous active-high reset, and a sequenced soft-clear engine that zeroes the array between layers without a global reset. Write-to-read forwarding is a compile-time option.

## Interface
- DATA_W, 8, entry width in bits
- DEPTH, 32, number of entries (≥2; need not be a power of two)
- NUM_RD, 4, number of read ports (≥1)
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data, same packing
- rd_valid  out  NUM_RD  per-port data valid
- clr_req  in  1  start soft clear (single-cycle pulse is sufficient)
- busy  out  1  soft clear in progress
- wr_err  out  1  one-cycle pulse: write rejected

## Operation
- Reset: all entries 0; rd_data 0; rd_valid 0; busy 0; wr_err 0; FSM in IDLE; clear counter 0.
- Write: in IDLE, wr_en with wr_addr < DEPTH updates the entry at the clock edge.
- Write rejection: the write is dropped and wr_err pulses on the next cycle when wr_addr ≥ DEPTH, the FSM is in CLEAR, or clr_req is accepted in the same cycle.
- Read: rd_en[p] captures entry rd_addr[p] into rd_data[p]. rd_addr[p] ≥ DEPTH captures 0. All ports are independent, and any ports may read the same address.
- rd_data[p] holds its last value while rd_en[p] is low.
- FSM states:
  - IDLE: clr_req goes to CLEAR with the counter at 0.
  - CLEAR: each cycle zeroes entry[counter] and increments the counter. When the counter reaches DEPTH-1, that entry is zeroed and the FSM returns to IDLE.
  - clr_req is ignored while in CLEAR.
- Reads during CLEAR are serviced. An entry already swept reads 0. The entry being zeroed in the current cycle returns its pre-clear value.
- Reset asserted mid-clear aborts the sweep. The array is zeroed by reset regardless.

## Timing
- Read latency is 1 cycle: rd_en/rd_addr at edge N give rd_data/rd_valid after edge N+1. rd_valid[p] is rd_en[p] registered.
- Write is visible to a read issued in the cycle after the write.
- Same-cycle write and read of the same address follow the Configuration section.
- Soft clear lasts exactly DEPTH cycles:
  - busy rises on the edge that accepts clr_req.
  - busy falls on the edge that clears entry DEPTH-1.
  - The first write accepted after a clear is in the cycle busy is low.
- wr_err asserts for one cycle, on the edge after the rejected request.

## Configuration
- REGFILE_BYPASS_EN defined: a read in the same cycle as an accepted write to the same address returns wr_data. A rejected write is never forwarded.
- REGFILE_BYPASS_EN undefined: that read returns the old entry value (read-before-write).
- All other behaviour is identical in both builds.

## Structure
- Package regfile_pkg holds:
  - the FSM state enum (IDLE, CLEAR);
  - default DATA_W, DEPTH and NUM_RD constants;
  - the address-in-range helper function.
- Sub-module regfile_clr_seq holds the clear FSM and counter. Its outputs are busy, clr_we and clr_addr.
- The top level holds:
  - the storage array and write arbitration (clear has priority over user writes);
  - a generate loop of NUM_RD read ports, including optional bypass.

## Test plan
- Reset/basic (DATA_W=8, DEPTH=32, NUM_RD=4): reset, write 0xA5 to address 3, then read address 3 on all ports → rd_data 0xA5 on all four ports one cycle later, rd_valid=4'b1111.
- Same-cycle hazard: hold address 7 = 0x11, then write 0x22 to address 7 while reading address 7. With REGFILE_BYPASS_EN → 0x22; without → 0x11; the following read → 0x22.
- Soft clear: fill all entries with 0xFF, pulse clr_req, and attempt a write during busy.
  - busy is high for exactly 32 cycles.
  - wr_err pulses for the attempted write.
  - Afterwards, all addresses read 0.
- Out of range (DEPTH=20): write to address 25 → wr_err pulse and no entry changes; read address 25 → rd_data 0, rd_valid 1.
- Reset mid-clear: assert rst at clear counter 10 → busy 0 immediately and all reads 0. A write accepted after reset reads back correctly.
- Hold/independence: port 0 reads address 1 (0x01) and then drops rd_en while port 1 keeps reading addresses 2 then 4 → rd_data[0] stays 0x01 with rd_valid[0]=0, and port 1 tracks its addresses.
